muldiv_iter: RTL

- Parametrised iterative multiply/divide unit for the execute stage; successor to the fixed-width 32-bit multicycle unit.
- Adds configurable width, configurable multiply throughput, signed/unsigned modes, a start/busy/ok handshake, flush abort and divide-by-zero reporting.
- Produces a HI/LO result pair that the memory stage writes back.

---
 rtl/muldiv_iter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Multiply retires MUL_BITS multiplier bits per cycle (shift-add); divide is
// restoring radix-2, one quotient bit per cycle. Signed ops work on
// magnitudes and fix signs in a single FIX cycle before the DONE pulse.
// Optional feature macro: MULDIV_ACC_EN enables MADD/MADDU/MSUB/MSUBU
// (ops 4-7), which fold {acc_hi,acc_lo} into the result in FIX.
module muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             busy,
  output logic             ok,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int NM    = WIDTH / MUL_BITS;
  localparam int ND    = WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic               sign_q, sign_r, div_q, dbz_q;

  logic               accept, is_div, is_signed, is_acc, zero_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+MUL_BITS-1:0] mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_s, fix_val;
  logic [WIDTH-1:0]   quo_s, rem_s;

`ifdef MULDIV_ACC_EN
  logic [2*WIDTH-1:0] acc_q;
  logic               acc_en_q, sub_q;
  assign is_acc = op[2];
`else
  logic unused_acc;
  assign unused_acc = ^{acc_hi, acc_lo};
  assign is_acc     = 1'b0;
`endif

  // Request decode: ops 4-7 fall back to MULTU when accumulation is absent.
  assign accept    = (state == S_IDLE) && start && !flush;
  assign is_div    = (op == 3'd2) || (op == 3'd3);
  assign is_signed = !op[0] && (!op[2] || is_acc);
  assign zero_div  = is_div && (b == '0);
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign ok   = (state == S_DONE);

  // Iteration datapath and sign/accumulate correction for FIX.
  always_comb begin
    mul_sum   = {{MUL_BITS{1'b0}}, prod[2*WIDTH-1:WIDTH]}
              + ({{MUL_BITS{1'b0}}, opnd} * {{WIDTH{1'b0}}, prod[MUL_BITS-1:0]});
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = !div_diff[WIDTH];
    prod_s    = sign_q ? -prod : prod;
    quo_s     = sign_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_s     = sign_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    fix_val   = prod_s;
`ifdef MULDIV_ACC_EN
    if (acc_en_q) fix_val = sub_q ? (acc_q - prod_s) : (acc_q + prod_s);
`endif
    if (div_q) fix_val = {rem_s, quo_s};
    if (dbz_q) fix_val = prod;  // fast path preloaded {a, all-ones}
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) nxt = zero_div ? S_FIX : (is_div ? S_DIV : S_MUL);
      S_MUL:  if (cnt == CNT_W'(NM - 1)) nxt = S_FIX;
      S_DIV:  if (cnt == CNT_W'(ND - 1)) nxt = S_FIX;
      S_FIX:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (flush) nxt = S_IDLE;
  end

  // State register and iteration counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (accept) cnt <= '0;
      else if (state == S_MUL || state == S_DIV) cnt <= cnt + 1'b1;
    end
  end

  // Architectural results: written only on an unflushed FIX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= 1'b0;
    end else if (state == S_FIX && !flush) begin
      hi          <= fix_val[2*WIDTH-1:WIDTH];
      lo          <= fix_val[WIDTH-1:0];
      div_by_zero <= dbz_q;
    end
  end

  // Operand latch and per-cycle shift-add / restoring-divide step.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      sign_r <= is_signed && a[WIDTH-1];
      div_q  <= is_div;
      dbz_q  <= zero_div;
      opnd   <= is_div ? b_mag : a_mag;
      if (zero_div)    prod <= {a, {WIDTH{1'b1}}};
      else if (is_div) prod <= {{WIDTH{1'b0}}, a_mag};
      else             prod <= {{WIDTH{1'b0}}, b_mag};
`ifdef MULDIV_ACC_EN
      acc_q    <= {acc_hi, acc_lo};
      acc_en_q <= op[2];
      sub_q    <= op[2] && op[1];
`endif
    end else if (state == S_MUL) begin
      prod <= {mul_sum, prod[WIDTH-1:MUL_BITS]};
    end else if (state == S_DIV) begin
      prod <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
               prod[WIDTH-2:0], div_ge};
    end
  end

endmodule
